// File: rtl/pipe_fixed_point_sqrt_stream.sv
// Pipelined signed fixed-point square root (restoring, BPS root bits per stage) with valid/ready, tag and neg flag.
// Optional FXSQRT_EXACT_EN adds o_out_exact (final remainder zero and no non-zero bits dropped).
module pipe_fixed_point_sqrt_stream #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1,
  parameter int BPS   = 1,
  parameter int TAGW  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WII+WIF-1:0]   i_in,
  input  logic [TAGW-1:0]      i_in_tag,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WOI+WOF-1:0]   o_out,
  output logic [TAGW-1:0]      o_out_tag,
  output logic                 o_overflow,
  output logic                 o_neg_err
`ifdef FXSQRT_EXACT_EN
  ,
  output logic                 o_out_exact
`endif
);

  localparam int WI  = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int WRI = (WII + 1) / 2;
  localparam int NR  = WRI + WIF;
  localparam int WR  = 2 * NR;
  localparam int S   = (NR + BPS - 1) / BPS;
  localparam int SHL = (WOF > WIF) ? (WOF - WIF) : 0;
  localparam int SHR = (WIF > WOF) ? (WIF - WOF) : 0;
  localparam int WW  = (((NR + SHL + 1) > WO) ? (NR + SHL + 1) : WO) + 1;

  localparam logic [WW-1:0] HALF = (ROUND != 0 && SHR > 0) ? WW'((2 ** SHR) / 2) : '0;
  localparam logic [WW-1:0] MAXP = WW'({(WO-1){1'b1}});

  typedef struct packed {
    logic [WR-1:0] rem;
    logic [NR-1:0] root;
  } st_t;

  // Stage k retires root bits NR-1-k*BPS downward; positions below 0 are the zero padding of the last stage.
  function automatic st_t f_iter(input st_t a, input int unsigned k);
    logic [WR-1:0] rem;
    logic [NR-1:0] q;
    logic [WR:0]   t;
    int            p;
    st_t           r;
    rem = a.rem;
    q   = a.root;
    for (int unsigned j = 0; j < BPS; j++) begin
      p = NR - 1 - (int'(k) * BPS + int'(j));
      if (p >= 0) begin
        t = ((WR+1)'(q) << (p + 1)) | ((WR+1)'(1) << (2 * p));
        if (t <= {1'b0, rem}) begin
          rem = rem - t[WR-1:0];
          q   = q | (NR'(1) << p);
        end
      end
    end
    r.rem  = rem;
    r.root = q;
    return r;
  endfunction

`ifndef FXSQRT_EXACT_EN
  function automatic logic [NR-1:0] f_root(input st_t a, input int unsigned k);
    st_t r;
    r = f_iter(a, k);
    return r.root;
  endfunction
`endif

  logic            w_en;
  logic            w_neg;
  logic [WR-1:0]   w_rad;
  logic            r_vld [0:S];
  logic [TAGW-1:0] r_tag [0:S];
  logic            r_neg [0:S];
  st_t             r_st  [0:S-1];
  logic [NR-1:0]   w_root_l;
`ifdef FXSQRT_EXACT_EN
  st_t             r_last;
  assign w_root_l = r_last.root;
`else
  logic [NR-1:0]   r_root_l;
  assign w_root_l = r_root_l;
`endif

  assign w_en       = !o_out_valid || i_out_ready;
  assign o_in_ready = w_en;
  assign w_neg      = i_in[WI-1];
  assign w_rad      = w_neg ? '0 : (WR'(i_in[WI-2:0]) << WIF);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int unsigned s = 0; s <= S; s++) begin
        r_vld[s] <= 1'b0;
        r_tag[s] <= '0;
        r_neg[s] <= 1'b0;
      end
      for (int unsigned s = 0; s < S; s++) r_st[s] <= '0;
`ifdef FXSQRT_EXACT_EN
      r_last <= '0;
`else
      r_root_l <= '0;
`endif
    end else if (w_en) begin
      r_vld[0]     <= i_in_valid;
      r_tag[0]     <= i_in_tag;
      r_neg[0]     <= w_neg;
      r_st[0].rem  <= w_rad;
      r_st[0].root <= '0;
      for (int unsigned s = 1; s <= S; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
        r_neg[s] <= r_neg[s-1];
      end
      for (int unsigned s = 1; s < S; s++) r_st[s] <= f_iter(r_st[s-1], s - 1);
`ifdef FXSQRT_EXACT_EN
      r_last <= f_iter(r_st[S-1], S - 1);
`else
      r_root_l <= f_root(r_st[S-1], S - 1);
`endif
    end
  end

  logic [WW-1:0] w_ext;
  logic [WW-1:0] w_scaled;
  logic          w_ovf;
  logic [WO-1:0] w_res;

  always_comb begin
    w_ext    = WW'(w_root_l) << SHL;
    w_scaled = (w_ext + HALF) >> SHR;
    w_ovf    = !r_neg[S] && (w_scaled > MAXP);
    w_res    = '0;
    if (!r_neg[S]) w_res = w_ovf ? MAXP[WO-1:0] : w_scaled[WO-1:0];
  end

`ifdef FXSQRT_EXACT_EN
  localparam logic [NR-1:0] DROPM = NR'((2 ** SHR) - 1);
  logic w_exact;
  logic r_exact;
  always_comb begin
    w_exact = (r_last.rem == '0) && ((w_root_l & DROPM) == '0) && !w_ovf && !r_neg[S];
  end
  assign o_out_exact = r_exact;
`endif

  logic            r_ovalid;
  logic [WO-1:0]   r_out;
  logic [TAGW-1:0] r_otag;
  logic            r_ovf;
  logic            r_oneg;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_ovalid <= 1'b0;
      r_out    <= '0;
      r_otag   <= '0;
      r_ovf    <= 1'b0;
      r_oneg   <= 1'b0;
`ifdef FXSQRT_EXACT_EN
      r_exact  <= 1'b0;
`endif
    end else if (w_en) begin
      r_ovalid <= r_vld[S];
      r_out    <= w_res;
      r_otag   <= r_tag[S];
      r_ovf    <= w_ovf;
      r_oneg   <= r_neg[S];
`ifdef FXSQRT_EXACT_EN
      r_exact  <= w_exact;
`endif
    end
  end

  assign o_out_valid = r_ovalid;
  assign o_out       = r_out;
  assign o_out_tag   = r_otag;
  assign o_overflow  = r_ovf;
  assign o_neg_err   = r_oneg;

endmodule

// File: tb/tb_pipe_fixed_point_sqrt_stream.sv
// Bench for pipe_fixed_point_sqrt_stream: BPS=1..4 instances plus a WOI=4 instance, scoreboarded against an integer-sqrt model.
module tb_pipe_fixed_point_sqrt_stream;
  localparam int NI = 5;
`ifdef FXSQRT_EXACT_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        vin;
  logic [15:0] din;
  logic [3:0]  tin;
  logic        ordy [NI];
  logic        irdy [NI];
  logic        ovld [NI];
  logic [15:0] oout [NI];
  logic [3:0]  otag [NI];
  logic        oovf [NI];
  logic        oneg [NI];
  logic        oex  [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int npop0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BP  = (g < 4) ? g + 1 : 1;
    localparam int WOG = (g < 4) ? 8 : 4;
    logic [WOG+8-1:0] w_o;
    pipe_fixed_point_sqrt_stream #(
      .WII(8), .WIF(8), .WOI(WOG), .WOF(8), .ROUND(1), .BPS(BP), .TAGW(4)
    ) u_dut (
      .i_clk(clk), .i_rstn(rstn), .i_in_valid(vin), .o_in_ready(irdy[g]),
      .i_in(din), .i_in_tag(tin), .o_out_valid(ovld[g]), .i_out_ready(ordy[g]),
      .o_out(w_o), .o_out_tag(otag[g]), .o_overflow(oovf[g]), .o_neg_err(oneg[g])
`ifdef FXSQRT_EXACT_EN
      , .o_out_exact(oex[g])
`endif
    );
    assign oout[g] = 16'(w_o);
`ifndef FXSQRT_EXACT_EN
    assign oex[g] = 1'b0;
`endif
  end

  // Model: root = floor(sqrt(x * 2^8)) in 4.8 format, saturated to the output range.
  function automatic logic [31:0] ref_enc(input logic [15:0] x, input logic [3:0] t, input int woi);
    longint r, rr, maxp;
    logic [15:0] o;
    logic ovf, ex;
    o = '0; ovf = 1'b0; ex = 1'b0;
    if (!x[15]) begin
      rr = longint'(x) * 256;
      r  = longint'($sqrt(real'(rr)));
      while (r * r > rr) r--;
      while ((r + 1) * (r + 1) <= rr) r++;
      maxp = (longint'(1) << (woi + 7)) - 1;
      if (r > maxp) begin o = 16'(maxp); ovf = 1'b1; end
      else begin o = 16'(r); ex = (r * r == rr); end
    end
    return {9'b0, ex & EXACT, x[15], ovf, t, o};
  endfunction

  function automatic logic [31:0] act_enc(input int g);
    return {9'b0, oex[g], oneg[g], oovf[g], otag[g], oout[g]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [31:0] sb [NI][$];

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        for (int g = 0; g < NI; g++) sb[g].delete();
      end else begin
        for (int g = 0; g < NI; g++) begin
          if (ovld[g] && ordy[g]) begin
            if (g == 0) npop0++;
            if (sb[g].size() == 0) begin
              total++; bad++;
              $display("FAIL mon%0d: unexpected beat got %h want none", g, act_enc(g));
            end else begin
              e = sb[g].pop_front();
              chk($sformatf("mon%0d", g), act_enc(g), e);
            end
          end
          if (vin && irdy[g]) sb[g].push_back(ref_enc(din, tin, (g == 4) ? 4 : 8));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] d, input logic [3:0] t, input int sel, output int lat);
    int t0;
    @(posedge clk); #1;
    vin = 1'b1; din = d; tin = t; t0 = cyc;
    @(posedge clk); #1;
    vin = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ovld[sel]) break;
    end
    lat = cyc - t0;
  endtask

  function automatic logic [15:0] op(input int k);
    return 16'((k + 1) * 311) & 16'h7FFF;
  endfunction

  typedef struct {
    int          sel;
    logic [15:0] d;
    logic [3:0]  t;
    logic [15:0] o;
    logic        ovf;
    logic        neg;
    logic        ex;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lat;
    int lats [NI];
    int t0, sent, base;
    tbl[0]  = '{0, 16'h1000, 4'd3, 16'h0400, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{0, 16'h0200, 4'd5, 16'h016A, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{0, 16'h7FFF, 4'd7, 16'h0B50, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0, 16'h0000, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{0, 16'h0100, 4'd2, 16'h0100, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{0, 16'h0001, 4'd9, 16'h0010, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{0, 16'hFF00, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{0, 16'h8000, 4'd15, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{4, 16'h7FFF, 4'd6, 16'h07FF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4, 16'hFF00, 4'd8, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4, 16'h4000, 4'd10, 16'h07FF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4, 16'h3100, 4'd11, 16'h0700, 1'b0, 1'b0, 1'b1};

    rstn = 1'b0; vin = 1'b0; din = '0; tin = '0;
    for (int g = 0; g < NI; g++) ordy[g] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset", {ovld[0], irdy[0], oout[0], otag[0], oovf[0], oneg[0], oex[0]},
        {1'b0, 1'b1, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      send(tbl[i].d, tbl[i].t, tbl[i].sel, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd14);
      chk($sformatf("vec%0d", i), act_enc(tbl[i].sel),
          {9'b0, tbl[i].ex & EXACT, tbl[i].neg, tbl[i].ovf, tbl[i].t, tbl[i].o});
    end
    repeat (20) @(posedge clk);

    // Latency per BPS: ceil(12/BPS)+2.
    @(posedge clk); #1;
    vin = 1'b1; din = 16'h0900; tin = 4'd12; t0 = cyc;
    for (int g = 0; g < NI; g++) lats[g] = -1;
    @(posedge clk); #1 vin = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (ovld[g] && lats[g] < 0) lats[g] = cyc - t0;
    end
    chk("lat_bps1", 32'(lats[0]), 32'd14);
    chk("lat_bps2", 32'(lats[1]), 32'd8);
    chk("lat_bps3", 32'(lats[2]), 32'd6);
    chk("lat_bps4", 32'(lats[3]), 32'd5);
    chk("lat_woi4", 32'(lats[4]), 32'd14);
    repeat (5) @(posedge clk);

    // Stall: 20 beats, out_ready[0] low for stream cycles 16..20 while beat 2 sits at the output.
    sent = 0; base = npop0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      ordy[0] = !(c >= 16 && c <= 20);
      vin = (sent < 20);
      din = op(sent);
      tin = 4'(sent);
      @(negedge clk);
      if (c >= 16 && c <= 20) begin
        chk($sformatf("stall_c%0d", c), {29'b0, irdy[0], ovld[0], 1'b0} | 32'(otag[0]) << 8,
            {29'b0, 1'b0, 1'b1, 1'b0} | (32'd2 << 8));
        chk($sformatf("stall_out_c%0d", c), act_enc(0), ref_enc(op(2), 4'd2, 8));
      end
      if (vin && irdy[0]) sent++;
    end
    ordy[0] = 1'b1;
    chk("stall_count", 32'(npop0 - base), 32'd20);

    // Mid-stream reset with 6 beats in flight.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      vin = 1'b1; din = op(c + 40); tin = 4'(c);
    end
    @(posedge clk); #1;
    vin = 1'b0; rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_valid", {27'b0, ovld[0], ovld[1], ovld[2], ovld[3], ovld[4]}, 32'd0);
    repeat (30) @(posedge clk);
    send(16'h1000, 4'd3, 0, lat);
    chk("rst_lat", 32'(lat), 32'd14);
    chk("rst_first", act_enc(0), ref_enc(16'h1000, 4'd3, 8));
    repeat (20) @(posedge clk);

    // Random stream with random back-pressure on every instance.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      vin = ($urandom_range(4) != 0);
      din = 16'($urandom);
      if ($urandom_range(3) != 0) din[15] = 1'b0;
      if ($urandom_range(31) == 0) din = '0;
      tin = 4'($urandom);
      for (int g = 0; g < NI; g++) ordy[g] = ($urandom_range(7) != 0);
    end
    @(posedge clk); #1;
    vin = 1'b0;
    for (int g = 0; g < NI; g++) ordy[g] = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) chk($sformatf("drain%0d", g), 32'(sb[g].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
